// File: rtl/drink_moore_fsm.sv
// -----------------------------------------------------------------------------
// drink_moore_fsm
//
// Moore vending controller for a drink priced at 2.5 units. Accepts 0.5-unit
// (half) and 1-unit (one) coins, one coin event per clock. Credit is counted
// in half-units. A drink is dispensed (out) for exactly one cycle once the
// credit reaches 5 half-units. The change strobe (cout) rises together with
// out when the credit overshoots to 6 half-units.
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   reset   in   synchronous active-low reset, sampled on the rising edge
//   half    in   0.5-unit coin present this cycle
//   one     in   1-unit coin present this cycle (wins over half if both set)
//   out     out  drink dispense strobe, registered decode of state
//   cout    out  0.5-unit change strobe, registered decode of state
//   credit  out  (only with CREDIT_MON_EN) current credit in half-units, 0..6
//
// Configuration macro: CREDIT_MON_EN adds the credit monitor output.
//
// Coin handshake: half/one are plain levels. Every rising edge with reset
// high consumes whatever coin is presented. There is no backpressure.
// -----------------------------------------------------------------------------
module drink_moore_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       half,
    input  logic       one,
    output logic       out,
    output logic       cout
`ifdef CREDIT_MON_EN
    ,
    output logic [2:0] credit
`endif
);

    // The encoding equals the credit in half-units. This keeps the credit
    // monitor a direct copy of the next state. 3'd7 is unused and recovers
    // to S0.
    typedef enum logic [2:0] {
        S0       = 3'd0,
        S05      = 3'd1,
        S10      = 3'd2,
        S15      = 3'd3,
        S20      = 3'd4,
        VEND     = 3'd5,
        VEND_CHG = 3'd6
    } state_e;

    // Power-up values. Outputs are low before the first reset edge.
    state_e state_q  = S0;
    state_e state_d;
    logic   out_q    = 1'b0;
    logic   cout_q   = 1'b0;
`ifdef CREDIT_MON_EN
    logic [2:0] credit_q = 3'd0;
`endif

    // Next-state logic. The one coin takes priority over the half coin.
    // Leaving VEND or VEND_CHG restarts the credit at zero and accepts the
    // current coin in the same cycle.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:       state_d = one ? S10      : (half ? S05  : S0);
            S05:      state_d = one ? S15      : (half ? S10  : S05);
            S10:      state_d = one ? S20      : (half ? S15  : S10);
            S15:      state_d = one ? VEND     : (half ? S20  : S15);
            S20:      state_d = one ? VEND_CHG : (half ? VEND : S20);
            VEND,
            VEND_CHG: state_d = one ? S10      : (half ? S05  : S0);
            default:  state_d = S0;
        endcase
    end

    // Single state register.
    // The outputs are decoded from the next state and registered alongside
    // it, so they always equal a decode of the current state.
    // They are also glitch-free flop outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S0;
            out_q    <= 1'b0;
            cout_q   <= 1'b0;
`ifdef CREDIT_MON_EN
            credit_q <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            out_q    <= (state_d == VEND) || (state_d == VEND_CHG);
            cout_q   <= (state_d == VEND_CHG);
`ifdef CREDIT_MON_EN
            credit_q <= state_d;
`endif
        end
    end

    assign out  = out_q;
    assign cout = cout_q;
`ifdef CREDIT_MON_EN
    assign credit = credit_q;
`endif

endmodule

// File: tb/tb_drink_moore_fsm.sv
// -----------------------------------------------------------------------------
// tb_drink_moore_fsm
//
// Self-checking bench for drink_moore_fsm. Directed steps follow the test plan.
// A randomized phase follows, and every cycle is checked against a credit-
// arithmetic reference model through an expected-value queue.
// -----------------------------------------------------------------------------
module tb_drink_moore_fsm;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic half  = 1'b0;
    logic one   = 1'b0;
    logic out;
    logic cout;
`ifdef CREDIT_MON_EN
    logic [2:0] credit;
`endif

    always #5 clk = ~clk;

    drink_moore_fsm dut (
        .clk   (clk),
        .reset (reset),
        .half  (half),
        .one   (one),
        .out   (out),
        .cout  (cout)
`ifdef CREDIT_MON_EN
        ,
        .credit(credit)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];        // expected {out, cout}
`ifdef CREDIT_MON_EN
    logic [2:0] exp_cr_q[$];     // expected credit
`endif
    int checks = 0;
    int errors = 0;

    // Reference model: credit in half-units plus a "dispensing now" flag
    int m_credit = 0;
    bit m_vend   = 1'b0;
    bit m_chg    = 1'b0;

    task automatic model_step(input logic h, input logic o, input logic r);
        int coin;
        coin = o ? 2 : (h ? 1 : 0);
        if (!r) begin
            m_credit = 0;
            m_vend   = 1'b0;
            m_chg    = 1'b0;
        end else if (m_vend) begin
            // Dispense cycle is over. The credit restarts from this coin.
            m_vend   = 1'b0;
            m_chg    = 1'b0;
            m_credit = coin;
        end else begin
            m_credit = m_credit + coin;
            if (m_credit >= 5) begin
                m_vend   = 1'b1;
                m_chg    = (m_credit == 6);
                m_credit = 0;
            end
        end
        exp_q.push_back({m_vend, m_vend & m_chg});
`ifdef CREDIT_MON_EN
        exp_cr_q.push_back(m_vend ? (m_chg ? 3'd6 : 3'd5) : 3'(m_credit));
`endif
    endtask

    task automatic check(input string tag);
        logic [1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed out/cout=%b", tag, {out, cout});
        end else begin
            exp = exp_q.pop_front();
            assert ({out, cout} === exp) else begin
                errors++;
                $error("FAIL %s: out/cout observed=%b expected=%b", tag, {out, cout}, exp);
            end
        end
`ifdef CREDIT_MON_EN
        if (exp_cr_q.size() != 0) begin
            logic [2:0] ecr;
            ecr = exp_cr_q.pop_front();
            checks++;
            assert (credit === ecr) else begin
                errors++;
                $error("FAIL %s_credit: observed=%0d expected=%0d", tag, credit, ecr);
            end
        end
`endif
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, let the model follow the rising edge, sample 1ns later
    task automatic do_cycle(input logic h, input logic o, input logic r, input string tag);
        @(negedge clk);
        half  = h;
        one   = o;
        reset = r;
        @(posedge clk);
        model_step(h, o, r);
        #1;
        check(tag);
    endtask

    // ---------------- directed + random stimulus ----------------
    int n_out;
    int n_chg;

    initial begin
        // Power-up: outputs low before any edge
        #2;
        exp_q.push_back(2'b00);
`ifdef CREDIT_MON_EN
        exp_cr_q.push_back(3'd0);
`endif
        check("powerup");

        // Reset, and a coin presented under reset must be ignored
        do_cycle(1'b0, 1'b1, 1'b0, "reset_with_coin");
        do_cycle(1'b0, 1'b0, 1'b0, "reset_idle");

        // Continuous half: dispense on coins 5, 10, 15, no change
        n_out = 0;
        n_chg = 0;
        for (int i = 0; i < 15; i++) begin
            do_cycle(1'b1, 1'b0, 1'b1, "half_stream");
            if (out) n_out++;
            if (cout) n_chg++;
        end
        checks++;
        assert (n_out == 3 && n_chg == 0) else begin
            errors++;
            $error("FAIL half_stream_count: out=%0d cout=%0d expected 3/0", n_out, n_chg);
        end

        // Return to S0, then continuous one: out+cout on coins 3, 6, 9
        do_cycle(1'b0, 1'b0, 1'b1, "idle_after_half");
        n_out = 0;
        n_chg = 0;
        for (int i = 0; i < 9; i++) begin
            do_cycle(1'b0, 1'b1, 1'b1, "one_stream");
            if (out) n_out++;
            if (out && cout) n_chg++;
        end
        checks++;
        assert (n_out == 3 && n_chg == 3) else begin
            errors++;
            $error("FAIL one_stream_count: out=%0d chg=%0d expected 3/3", n_out, n_chg);
        end

        // half, one, half, one -> 1, 3, 4, 6 -> dispense with change
        do_cycle(1'b0, 1'b0, 1'b1, "idle_a");
        do_cycle(1'b1, 1'b0, 1'b1, "hoho_1");
        do_cycle(1'b0, 1'b1, 1'b1, "hoho_2");
        do_cycle(1'b1, 1'b0, 1'b1, "hoho_3");
        do_cycle(1'b0, 1'b1, 1'b1, "hoho_vend_chg");
        do_cycle(1'b0, 1'b0, 1'b1, "hoho_after");

        // one, one, half -> exact dispense. A one during VEND goes to S10.
        do_cycle(1'b0, 1'b1, 1'b1, "ooh_1");
        do_cycle(1'b0, 1'b1, 1'b1, "ooh_2");
        do_cycle(1'b1, 1'b0, 1'b1, "ooh_vend");
        do_cycle(1'b0, 1'b1, 1'b1, "ooh_one_in_vend");
        do_cycle(1'b0, 1'b0, 1'b1, "ooh_hold_s10");
        do_cycle(1'b1, 1'b0, 1'b1, "ooh_s15");
        do_cycle(1'b1, 1'b0, 1'b1, "ooh_s20");
        do_cycle(1'b1, 1'b0, 1'b1, "ooh_vend2");

        // Simultaneous half+one counts as one: 2, 4, then half -> 5
        do_cycle(1'b0, 1'b0, 1'b0, "reset_b");
        do_cycle(1'b1, 1'b1, 1'b1, "both_1");
        do_cycle(1'b1, 1'b1, 1'b1, "both_2");
        do_cycle(1'b1, 1'b0, 1'b1, "both_vend");
        do_cycle(1'b0, 1'b0, 1'b1, "both_after");

        // Reset at S15 with a one coin discards credit. Three ones then dispense.
        do_cycle(1'b1, 1'b0, 1'b1, "mid_half");
        do_cycle(1'b0, 1'b1, 1'b1, "mid_s15");
        do_cycle(1'b0, 1'b1, 1'b0, "mid_reset");
        do_cycle(1'b0, 1'b1, 1'b1, "post_rst_1");
        do_cycle(1'b0, 1'b1, 1'b1, "post_rst_2");
        do_cycle(1'b0, 1'b1, 1'b1, "post_rst_vend");

        // A reset glitch between edges is not sampled
        @(negedge clk);
        half  = 1'b1;
        one   = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        model_step(1'b1, 1'b0, 1'b1);
        #1;
        check("unsampled_reset");
        do_cycle(1'b1, 1'b0, 1'b1, "after_glitch");

        // Randomized stimulus against the model
        for (int i = 0; i < 300; i++) begin
            logic h;
            logic o;
            logic r;
            h = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 2) == 0);
            r = 1'($urandom_range(0, 24) != 0);
            do_cycle(h, o, r, "random");
        end

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
